// File: rtl/dram_block_responder_if.sv
// Block request/response bus between the data cache and its memory.
// req_* carry one block request; rsp_*, busy and proto_err flow back.
interface dram_block_responder_if #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 4
);
  logic [ADDR_W-1:0]                  req_address;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] req_wdata;
  logic                               req_rw;
  logic                               req_valid;
  logic [BLOCK_WORDS-1:0][WORD_W-1:0] rsp_rdata;
  logic                               rsp_ready;
  logic                               busy;
  logic                               proto_err;

  modport master (
    output req_address, req_wdata, req_rw, req_valid,
    input  rsp_rdata, rsp_ready, busy, proto_err
  );

  modport slave (
    input  req_address, req_wdata, req_rw, req_valid,
    output rsp_rdata, rsp_ready, busy, proto_err
  );
endinterface

// File: rtl/dram_block_responder.sv
// Fixed-latency block memory behind the cache mem_* bus.
// Ports: clock, reset (async active-low), bus (slave side of the block bus).
module dram_block_responder #(
  parameter int ADDR_W       = 32,
  parameter int WORD_W       = 32,
  parameter int BLOCK_WORDS  = 4,
  parameter int DEPTH_BLOCKS = 1024,
  parameter int LATENCY      = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  dram_block_responder_if.slave bus
);
  localparam int OFF   = $clog2(BLOCK_WORDS) + 2;
  localparam int IDX_W = $clog2(DEPTH_BLOCKS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] blk_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_in;
  logic [IDX_W-1:0] idx_rd;
  logic             rw_q;
  logic             rw_rd;
  logic             perr_q;
  logic             capture;
  blk_t             wdata_q;
  blk_t             rdata_q;
  blk_t             blk_rd;
  blk_t             mem [DEPTH_BLOCKS];
  logic             unused_addr;

  assign idx_in      = bus.req_address[OFF +: IDX_W];
  assign unused_addr = ^bus.req_address;
  assign capture     = bus.req_valid && (state != BUSY);

  // With LATENCY=1 the RESP entry edge is the capture edge,
  // so the lookup must use the incoming request fields.
  assign idx_rd = capture ? idx_in : idx_q;
  assign rw_rd  = capture ? bus.req_rw : rw_q;

  // Write-first: a commit on this same edge wins over the array.
  assign blk_rd = (state == RESP && rw_q && idx_q == idx_rd)
                ? wdata_q : mem[idx_rd];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.req_valid)
          state_nx = (LATENCY == 1) ? RESP : BUSY;
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) state_nx = RESP;
      end
      RESP: begin
        if (bus.req_valid)
          state_nx = (LATENCY == 1) ? RESP : BUSY;
        else
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.rsp_ready = (state == RESP);
    bus.busy      = (state != IDLE);
    bus.rsp_rdata = rdata_q;
    bus.proto_err = perr_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      idx_q   <= '0;
      rw_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (capture) begin
        idx_q   <= idx_in;
        rw_q    <= bus.req_rw;
        wdata_q <= bus.req_wdata;
        cnt     <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (state == BUSY && bus.req_valid) perr_q <= 1'b1;
      if (state_nx == RESP && !rw_rd) rdata_q <= blk_rd;
    end
  end

  // Storage is deliberately not reset; contents survive reset.
  always_ff @(posedge clock) begin
    if (state == RESP && rw_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_dram_block_responder.sv
// Scoreboard bench for dram_block_responder.
// Stimulus pushes expected responses; a monitor checks each rsp_ready.
module tb_dram_block_responder;
  localparam int LAT = 4;

  typedef logic [3:0][31:0] blk_t;
  typedef struct {
    blk_t d;
    int   cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  blk_t last_rd = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dram_block_responder_if bus ();

  dram_block_responder #(
    .ADDR_W(32), .WORD_W(32), .BLOCK_WORDS(4),
    .DEPTH_BLOCKS(1024), .LATENCY(LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (reset && bus.rsp_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ready", bus.rsp_ready, 1'b0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("rdata", bus.rsp_rdata, e.d);
      end
    end
  end

  // Called at a negedge; d is write data or, for a read, the expected block.
  task automatic issue(input logic [31:0] a, input logic w,
                       input blk_t d, input bit track);
    exp_t e;
    bus.req_address = a;
    bus.req_rw      = w;
    bus.req_wdata   = w ? d : ~d;
    bus.req_valid   = 1'b1;
    if (track) begin
      if (!w) last_rd = d;
      e.d   = last_rd;
      e.cyc = cyc + LAT;
      q.push_back(e);
    end
    @(negedge clock);
    bus.req_valid   = 1'b0;
    bus.req_address = 32'hdead_beef;
    bus.req_wdata   = '1;
    bus.req_rw      = ~w;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      chk("timeout_pending", q.size(), 0);
      q.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  blk_t d1, da, db, dp, dq, dc;

  initial begin
    d1 = {32'd4, 32'd3, 32'd2, 32'd1};
    da = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    db = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    dp = {32'h5003, 32'h5002, 32'h5001, 32'h5000};
    dq = {32'h6003, 32'h6002, 32'h6001, 32'h6000};
    dc = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    bus.req_address = '0;
    bus.req_wdata   = '0;
    bus.req_rw      = 1'b0;
    bus.req_valid   = 1'b0;

    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_ready", bus.rsp_ready, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rdata", bus.rsp_rdata, 128'h0);
    chk("rst_proto_err", bus.proto_err, 1'b0);

    issue(32'h40, 1'b1, d1, 1'b1);
    chk("busy_inflight", bus.busy, 1'b1);
    wait_idle();
    issue(32'h48, 1'b0, d1, 1'b1);
    wait_idle();

    issue(32'h100, 1'b1, da, 1'b1);
    for (int i = 0; i < 20 && bus.rsp_ready !== 1'b1; i++)
      @(negedge clock);
    chk("b2b_ready_seen", bus.rsp_ready, 1'b1);
    issue(32'h100, 1'b0, da, 1'b1);
    wait_idle();

    chk("pre_proto_err", bus.proto_err, 1'b0);
    issue(32'h300, 1'b1, db, 1'b1);
    bus.req_address = 32'h40;
    bus.req_rw      = 1'b0;
    bus.req_valid   = 1'b1;
    @(negedge clock);
    bus.req_valid   = 1'b0;
    wait_idle();
    repeat (4) @(negedge clock);
    chk("proto_err_set", bus.proto_err, 1'b1);
    issue(32'h300, 1'b0, db, 1'b1);
    wait_idle();
    chk("proto_err_sticky", bus.proto_err, 1'b1);

    issue(32'h200, 1'b1, dp, 1'b1);
    wait_idle();
    issue(32'h200, 1'b1, dq, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_ready", bus.rsp_ready, 1'b0);
    chk("mid_rst_proto_err", bus.proto_err, 1'b0);
    chk("mid_rst_rdata", bus.rsp_rdata, 128'h0);
    @(negedge clock);
    reset = 1'b1;
    last_rd = '0;
    repeat (8) @(negedge clock);
    issue(32'h200, 1'b0, dp, 1'b1);
    wait_idle();

    issue(32'h0, 1'b1, dc, 1'b1);
    wait_idle();
    issue(32'h4000, 1'b0, dc, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
